// File: rtl/m10k_stream_reader.sv
// Read-side controller for an M10K block RAM. Issues sequential, wrapping read
// addresses, tracks the two-cycle registered read latency with a valid pipe, and
// delivers returned words through a skid FIFO as a valid/ready stream.
module m10k_stream_reader #(
  parameter int unsigned ITE_NUM    = 100,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [ADDR_WIDTH-1:0]        i_base_addr,
  input  logic [ADDR_WIDTH:0]          i_len,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [ADDR_WIDTH-1:0]        o_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] i_rd_q,
  output logic signed [DATA_WIDTH-1:0] o_m_data,
  output logic                         o_m_valid,
  input  logic                         i_m_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthL = (CntW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] IteL = (ADDR_WIDTH+1)'(ITE_NUM);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ITE_NUM - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic [2:0]              r_v;          // r_v[0]=v0 .. r_v[2]=v2
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_bad_base;
  logic                    w_start_ok;
  logic                    w_can_issue;
  logic                    w_issue;
  logic [CntW:0]           w_occ;
  logic [ADDR_WIDTH-1:0]   w_addr_next;

  assign w_push      = r_v[2];
  assign w_pop       = o_m_valid && i_m_ready;
  assign w_bad_base  = {1'b0, i_base_addr} >= IteL;
  assign w_start_ok  = (r_state == StIdle) && i_start && !w_bad_base && (i_len != '0);
  // Pre-pop occupancy including every read still in flight: conservative, so the
  // FIFO can never be overrun by words already requested from the RAM.
  assign w_occ       = {1'b0, r_count} + {{CntW{1'b0}}, r_v[0]}
                     + {{CntW{1'b0}}, r_v[1]} + {{CntW{1'b0}}, r_v[2]};
  assign w_can_issue = (r_state == StIssue) && (r_remaining != '0) && (w_occ < DepthL);
  assign w_issue     = w_start_ok || w_can_issue;
  assign w_addr_next = (r_rd_addr == LastAddr) ? '0 : r_rd_addr + ADDR_WIDTH'(1);

  // Control FSM: issue sequencing, latency pipe and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_v         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_v    <= {r_v[1:0], w_issue};
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_bad_base) begin
              r_err <= 1'b1;
            end else if (i_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rd_addr   <= i_base_addr;
              r_remaining <= i_len - (ADDR_WIDTH+1)'(1);
              r_busy      <= 1'b1;
              r_state     <= (i_len == (ADDR_WIDTH+1)'(1)) ? StDrain : StIssue;
            end
          end
        end
        StIssue: begin
          if (w_can_issue) begin
            r_rd_addr   <= w_addr_next;
            r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
            if (r_remaining == (ADDR_WIDTH+1)'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          // Last word leaves the FIFO with nothing behind it in the RAM pipe.
          if (w_pop && (r_count == CntW'(1)) && (r_v == '0)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Skid FIFO: captures each RAM word the cycle after it is tagged by v2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_rd_q;
        r_wptr        <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_rd_addr = r_rd_addr;
  assign o_m_valid = (r_count != '0);
  assign o_m_data  = r_mem[r_rptr];

endmodule

// File: doc/m10k_stream_reader.md
# m10k_stream_reader

Read-side controller for the M10K block RAM. Given a base address and a word count, it issues sequential read addresses to the RAM's read port and compensates for the RAM's two-cycle registered read latency. It delivers the returned words as a valid/ready stream to the MAC datapath, buffering in-flight data in a small skid FIFO so backpressure never drops a word.

## Interface
- `ITE_NUM`, 100: RAM depth in words; addresses wrap modulo `ITE_NUM`.
- `DATA_WIDTH`, 10: word width; must match the RAM.
- `ADDR_WIDTH`, 10: RAM address width.
- `FIFO_DEPTH`, 8: skid FIFO depth, power of two. Minimum legal value 4. Must be ≥5 for 1 word/cycle throughput.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; must be < `ITE_NUM`.
- `len`  in  ADDR_WIDTH+1  number of words, 0..`ITE_NUM`.
- `busy`  out  1  high from accepted start until the cycle `done` asserts.
- `done`  out  1  one-cycle pulse at burst completion.
- `err`  out  1  one-cycle pulse when `start` is rejected for `base_addr` ≥ `ITE_NUM`.
- `rd_addr`  out  ADDR_WIDTH  registered, drives RAM `read_address`.
- `rd_q`  in  DATA_WIDTH signed  RAM `q`.
- `m_data`  out  DATA_WIDTH signed  stream data, the FIFO head.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.

## Operation
- States:
  - IDLE: `busy`=0.
  - ISSUE: words remain to be issued.
  - DRAIN: all words issued; waiting for in-flight reads and the FIFO to empty.
- IDLE, `start`=1:
  - `base_addr` ≥ `ITE_NUM`: `err` pulses, stay in IDLE.
  - else `len`=0: `done` pulses next cycle, stay in IDLE, no read issued.
  - else: go to ISSUE and issue the first read on the same edge (`rd_addr`←`base_addr`), remaining←`len`−1.
- `start` while `busy` is ignored.
- Issue tracking:
  - A 3-stage valid shift register (v0, v1, v2) tags each issued read.
  - v0 is set on the issue edge.
  - v2 high means `rd_q` holds that word, and the FIFO writes `rd_q` on the next edge.
- Issue permission:
  - in ISSUE, remaining>0 and (FIFO count + v0 + v1 + v2) < `FIFO_DEPTH`.
  - FIFO count is the pre-pop value; the check is conservative, so the FIFO never overflows.
- On each issue, `rd_addr`←(`rd_addr`+1, wrapping to 0 when it equals `ITE_NUM`−1) and remaining decrements.
- When remaining reaches 0, go to DRAIN.
- `rd_addr` holds its value when not issuing.
- FIFO:
  - Push when v2 is high; pop on `m_valid`&&`m_ready`.
  - Simultaneous push and pop leaves count unchanged.
  - `m_valid` = FIFO non-empty and never depends combinationally on `m_ready`.
  - `m_data` is stable while `m_valid`&&!`m_ready`.
- Completion: on the edge where the last word is accepted (DRAIN, FIFO count 1, pop, no in-flight), go to IDLE with `busy`←0 and `done`←1 for one cycle.
- Reset:
  - All outputs 0; state IDLE; FIFO, counters and valid pipe cleared asynchronously.
  - Mid-burst reset discards all in-flight data; no `done` is generated.

## Timing
- `start` sampled at edge S ⇒ `rd_addr`=`base_addr` from S; RAM samples it at S+1; `rd_q` is valid after S+2; FIFO push at S+3; `m_valid` high from S+3.
- With `m_ready` held 1 and `FIFO_DEPTH` ≥5, one word per cycle, back to back.
- `done` is asserted in the cycle after the final handshake edge; `busy` falls on the same edge.
- A new `start` is accepted the cycle `done` is high (state is already IDLE).

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle -> `busy`, `done`, `err`, `m_valid`, `rd_addr` all 0 immediately.
- Basic burst: mem[i]=3·i, `base_addr`=3, `len`=5, `m_ready`=1 -> `m_data` 9,12,15,18,21 on 5 consecutive cycles starting edge S+3; `done` pulses once, the cycle after the 5th handshake.
- Wrap: `ITE_NUM`=100, `base_addr`=98, `len`=4 -> `rd_addr` 98,99,0,1; data in that order.
- Backpressure: `len`=20, `m_ready`=0 for 10 cycles after the 2nd word -> `rd_addr` stalls with FIFO count + in-flight ≤ `FIFO_DEPTH`; `m_data` stable; all 20 words delivered in order with no loss or duplication.
- Edge requests:
  - `len`=0 -> `done` next cycle, `m_valid` never asserts.
  - `base_addr`=100 -> `err` pulse, `busy` stays 0.
  - `start` during a burst -> ignored.
- Reset mid-burst: assert `rst_n`=0 after 3 of 10 words -> outputs clear; a following burst (`base_addr`=0, `len`=2) returns mem[0], mem[1] only.
